fattree_endpoint_ni: RTL and testbench
======================================

# fattree_endpoint_ni

Endpoint network interface that connects one processing element to one leaf-router port of the fat-tree NoC. It is the endpoint side of the router channel interface. On transmit it packetizes requests into head/body/tail flits, carrying the destination as the fat-tree base-K digit address and honouring credit flow control. On receive it buffers incoming flits, returns credits, and decodes the source address. One instance sits on each endpoint index `pos` of the fat-tree top.

## Interface
Parameters:
- NOC_ID, 0, NoC instance tag.
- K, 2, fat-tree radix.
- L, 2, number of tree levels.
- Fw, 32, flit width; bit Fw-1 = head flag, bit Fw-2 = tail flag, bits Fw-3:0 = payload.
- B, 4, router input-buffer depth in flits; equals the initial TX credit count.
- MAXLEN, 16, maximum number of body flits per packet.
- RXD, 4, receive FIFO depth; the upstream router must be configured with RXD credits.
- Derived values:
  - Kw = clog2(K).
  - NE = K^L.
  - NEw = clog2(NE).
  - DAw = L*Kw.
  - LENw = clog2(MAXLEN+1).
  - Fw-2 must be ≥ 2*DAw + LENw.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- src_id  in  NEw  this endpoint's index; static.
- tx_req_valid  in  1  packet request.
- tx_req_ready  out  1  request accepted.
- tx_dst  in  NEw  destination endpoint.
- tx_len  in  LENw  body flit count, 0..MAXLEN.
- tx_data_valid  in  1  body payload valid.
- tx_data_ready  out  1  body payload accepted.
- tx_data  in  Fw-2  body payload.
- tx_err  out  1  one-cycle pulse when a request is dropped.
- flit_out  out  Fw  flit to router.
- flit_out_wr  out  1  flit_out valid.
- credit_in  in  1  one credit returned by router.
- flit_in  in  Fw  flit from router.
- flit_in_wr  in  1  flit_in valid.
- credit_out  out  1  one credit returned to router.
- rx_valid  out  1  receive data available.
- rx_ready  in  1  consumer accepts.
- rx_data  out  Fw-2  payload.
- rx_head  out  1  head flag of the current flit.
- rx_tail  out  1  tail flag of the current flit.
- rx_src  out  NEw  source endpoint of the current packet.
- rx_ovf  out  1  sticky overflow flag.

## Operation
- **Address encoding:** enc(x) puts digit i = (x / K^i) % K at bits [i*Kw +: Kw], for i = 0..L-1. The decoder is the inverse: x = Σ digit_i * K^i.
- **Header payload layout:**
  - [DAw-1:0] = enc(dst).
  - [2*DAw-1:DAw] = enc(src_id).
  - [2*DAw+LENw-1:2*DAw] = len.
  - All remaining payload bits are 0.
- **TX FSM states:** IDLE, HEAD, BODY.
  - **IDLE:**
    - tx_req_ready = 1.
    - On handshake, if tx_dst == src_id or tx_len > MAXLEN: pulse tx_err for one cycle, stay in IDLE.
    - Otherwise latch dst and len, go to HEAD.
  - **HEAD:**
    - Waits until credits > 0.
    - Then emits the header with head=1 and tail=(len==0), and decrements credits.
    - If len == 0, go to IDLE; otherwise set cnt = len and go to BODY.
  - **BODY:**
    - tx_data_ready = (credits > 0).
    - Each tx_data handshake emits a flit with head=0 and tail=(cnt==1), decrements cnt and decrements credits.
    - After the tail flit, go to IDLE.
- **Credit counter:**
  - Range 0..B; reset value B.
  - A credit_in and an emit in the same cycle leave the count unchanged.
  - credit_in while the count is B and no emit is occurring is ignored; the counter saturates at B.
- **RX path:**
  - flit_in_wr pushes flit_in into the RXD-deep FIFO.
  - A push while the FIFO is full drops the flit and sets rx_ovf (sticky until reset).
  - rx_valid = FIFO not empty; rx_data, rx_head and rx_tail come from the FIFO head entry.
  - rx_src is decoded combinationally from a header entry. On a header pop it is latched, and the latched value is presented for the body flits that follow.
  - Each pop (rx_valid & rx_ready) produces a one-cycle credit_out pulse, registered, on the next cycle.
  - A simultaneous push and pop on a full FIFO is legal and does not set rx_ovf.

## Timing
- **Reset values:**
  - All outputs are 0 while reset is high, including tx_req_ready.
  - Credits = B; FSM = IDLE; FIFO empty; rx_ovf = 0; rx_src latch = 0.
- **Reset mid-packet:** the packet is abandoned immediately. The NoC is reset together with the endpoint interfaces, so no tail is sent.
- **TX latency:**
  - flit_out and flit_out_wr are registered.
  - Request handshake at cycle t: FSM is in HEAD at t+1; flit_out_wr=1 with the header at t+2 if credits are available.
  - A body handshake at cycle t appears on flit_out at t+1.
  - With continuous credits and data, body flits stream at one per cycle.
  - tx_req_ready returns the cycle after the tail flit is issued.
- **RX latency:**
  - Push at cycle t gives rx_valid at t+1 (registered FIFO write).
  - Pop at cycle t gives credit_out=1 at t+1.
- **Simultaneous events:**
  - tx_err and a new request do not overlap, because a rejected request stays in IDLE and is accepted or rejected one per cycle.
  - credit_in and a flit emit in the same cycle leave the credit count unchanged.

## Test plan
All scenarios use K=2, L=2, Fw=32, B=4 unless noted. NE=4, DAw=2, LENw=5.
- **Basic packet:** src_id=1, request dst=3, len=2, data 0xA, 0xB, credits held full.
  - Header payload bits [8:0] = {5'd2, 2'b01, 2'b11} at t+2.
  - Bodies 0xA (tail=0) then 0xB (tail=1) on consecutive cycles.
- **Credit stall:** B=4, no credit_in, request len=7.
  - Exactly 4 flits are emitted, then flit_out_wr stays 0 and tx_data_ready=0.
  - Each credit_in pulse releases exactly one further flit.
- **Error:** tx_dst=src_id=2 → one tx_err pulse, no flit emitted. tx_len=17 → one tx_err pulse, no flit emitted.
- **Zero-length:** dst=2, len=0 → a single flit with head=1 and tail=1, enc(dst)=2'b10; FSM returns to IDLE.
- **RX path:** inject a header with src field 2'b11 plus 2 body flits, rx_ready=1.
  - rx_src=3 on all three flits.
  - Three credit_out pulses, each one cycle after its pop.
- **Overflow:** rx_ready=0, push 5 flits with RXD=4.
  - rx_ovf=1, the FIFO holds the first 4 flits, no credit_out.
  - Reset clears rx_ovf and the FIFO.

Source files
------------

// File: rtl/fattree_endpoint_ni.sv
// rtl/fattree_endpoint_ni.sv - fat-tree endpoint network interface (credit-based TX packetizer, RX FIFO)
module fattree_endpoint_ni #(
    parameter int NOC_ID = 0,
    parameter int K      = 2,
    parameter int L      = 2,
    parameter int Fw     = 32,
    parameter int B      = 4,
    parameter int MAXLEN = 16,
    parameter int RXD    = 4,
    localparam int Kw    = $clog2(K),
    localparam int NE    = K ** L,
    localparam int NEw   = $clog2(NE),
    localparam int DAw   = L * Kw,
    localparam int LENw  = $clog2(MAXLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NEw-1:0]  src_id,
    input  logic            tx_req_valid,
    output logic            tx_req_ready,
    input  logic [NEw-1:0]  tx_dst,
    input  logic [LENw-1:0] tx_len,
    input  logic            tx_data_valid,
    output logic            tx_data_ready,
    input  logic [Fw-3:0]   tx_data,
    output logic            tx_err,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic            credit_in,
    input  logic [Fw-1:0]   flit_in,
    input  logic            flit_in_wr,
    output logic            credit_out,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [Fw-3:0]   rx_data,
    output logic            rx_head,
    output logic            rx_tail,
    output logic [NEw-1:0]  rx_src,
    output logic            rx_ovf
);
    localparam int CW   = $clog2(B + 1);
    localparam int PW   = (RXD > 1) ? $clog2(RXD) : 1;
    localparam int CNTW = $clog2(RXD + 1);
    localparam logic [CW-1:0]   B_L      = CW'(B);
    localparam logic [LENw-1:0] MAXLEN_L = LENw'(MAXLEN);

    // Base-K digit i of x lands at bits [i*Kw +: Kw].
    function automatic logic [DAw-1:0] enc(input logic [NEw-1:0] x);
        logic [DAw-1:0] r;
        int unsigned v;
        r = '0;
        v = 32'(x);
        for (int i = 0; i < L; i++) begin
            r[i*Kw +: Kw] = Kw'(v % K);
            v = v / K;
        end
        return r;
    endfunction

    function automatic logic [NEw-1:0] dec(input logic [DAw-1:0] a);
        int unsigned x, pw;
        x  = 0;
        pw = 1;
        for (int i = 0; i < L; i++) begin
            x  = x + 32'(a[i*Kw +: Kw]) * pw;
            pw = pw * K;
        end
        return NEw'(x);
    endfunction

    typedef enum logic [1:0] {IDLE, HEAD, BODY} tx_state_t;

    tx_state_t       state;
    logic [NEw-1:0]  dst_q;
    logic [LENw-1:0] len_q, cnt_q;
    logic [CW-1:0]   credits;
    logic [Fw-1:0]   flit_q;
    logic            flit_wr_q, err_q;
    logic [Fw-3:0]   hdr_payload;
    logic            credit_avail, head_emit, body_emit, emit;

    assign credit_avail  = (credits != '0);
    assign tx_req_ready  = ~reset & (state == IDLE);
    assign tx_data_ready = ~reset & (state == BODY) & credit_avail;
    assign head_emit     = (state == HEAD) & credit_avail;
    assign body_emit     = tx_data_ready & tx_data_valid;
    assign emit          = head_emit | body_emit;

    always_comb begin
        hdr_payload = '0;
        hdr_payload[DAw-1:0]                = enc(dst_q);
        hdr_payload[2*DAw-1:DAw]            = enc(src_id);
        hdr_payload[2*DAw+LENw-1:2*DAw]     = len_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            credits   <= B_L;
            flit_q    <= '0;
            flit_wr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            flit_wr_q <= emit;
            err_q     <= 1'b0;
            // Simultaneous credit return and emit cancel; returns beyond B are dropped.
            if (emit && !credit_in)
                credits <= credits - 1'b1;
            else if (credit_in && !emit && credits != B_L)
                credits <= credits + 1'b1;
            case (state)
                IDLE: if (tx_req_valid) begin
                    if (tx_dst == src_id || tx_len > MAXLEN_L) begin
                        err_q <= 1'b1;
                    end else begin
                        dst_q <= tx_dst;
                        len_q <= tx_len;
                        state <= HEAD;
                    end
                end
                HEAD: if (head_emit) begin
                    flit_q <= {1'b1, (len_q == '0), hdr_payload};
                    if (len_q == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt_q <= len_q;
                        state <= BODY;
                    end
                end
                BODY: if (body_emit) begin
                    flit_q <= {1'b0, (cnt_q == LENw'(1)), tx_data};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == LENw'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flit_out    = reset ? '0 : flit_q;
    assign flit_out_wr = ~reset & flit_wr_q;
    assign tx_err      = ~reset & err_q;

    logic [Fw-1:0]   mem [RXD];
    logic [PW-1:0]   wp, rp;
    logic [CNTW-1:0] fill;
    logic            full, empty, push, pop, ovf_q, crd_q;
    logic [NEw-1:0]  src_latch, src_dec;
    logic [Fw-1:0]   head_entry;

    assign full       = (fill == CNTW'(RXD));
    assign empty      = (fill == '0);
    assign head_entry = mem[rp];
    assign pop        = ~empty & rx_ready;
    // A pop frees a slot in the same cycle, so push-on-full with pop is accepted.
    assign push       = flit_in_wr & (~full | pop);
    assign src_dec    = dec(head_entry[2*DAw-1:DAw]);

    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wp] <= flit_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            fill      <= '0;
            ovf_q     <= 1'b0;
            crd_q     <= 1'b0;
            src_latch <= '0;
        end else begin
            crd_q <= pop;
            if (push)
                wp <= (wp == PW'(RXD - 1)) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PW'(RXD - 1)) ? '0 : rp + 1'b1;
            if (push && !pop)
                fill <= fill + 1'b1;
            else if (pop && !push)
                fill <= fill - 1'b1;
            if (flit_in_wr && full && !pop)
                ovf_q <= 1'b1;
            if (pop && head_entry[Fw-1])
                src_latch <= src_dec;
        end
    end

    assign rx_valid   = ~reset & ~empty;
    assign rx_data    = rx_valid ? head_entry[Fw-3:0] : '0;
    assign rx_head    = rx_valid & head_entry[Fw-1];
    assign rx_tail    = rx_valid & head_entry[Fw-2];
    assign rx_src     = reset ? '0 : (rx_head ? src_dec : src_latch);
    assign credit_out = ~reset & crd_q;
    assign rx_ovf     = ~reset & ovf_q;

endmodule

// File: tb/tb_fattree_endpoint_ni.sv
// tb/tb_fattree_endpoint_ni.sv - directed self-checking bench for fattree_endpoint_ni
module tb_fattree_endpoint_ni;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  src_id;
    logic        tx_req_valid;
    logic        tx_req_ready;
    logic [1:0]  tx_dst;
    logic [4:0]  tx_len;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [29:0] tx_data;
    logic        tx_err;
    logic [31:0] flit_out;
    logic        flit_out_wr;
    logic        credit_in;
    logic [31:0] flit_in;
    logic        flit_in_wr;
    logic        credit_out;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] rx_data;
    logic        rx_head;
    logic        rx_tail;
    logic [1:0]  rx_src;
    logic        rx_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fattree_endpoint_ni dut (
        .clk(clk), .reset(reset), .src_id(src_id),
        .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
        .tx_dst(tx_dst), .tx_len(tx_len),
        .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready), .tx_data(tx_data),
        .tx_err(tx_err), .flit_out(flit_out), .flit_out_wr(flit_out_wr), .credit_in(credit_in),
        .flit_in(flit_in), .flit_in_wr(flit_in_wr), .credit_out(credit_out),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_head(rx_head), .rx_tail(rx_tail), .rx_src(rx_src), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total_cnt++; if (tx_req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", tx_req_ready); else pass_cnt++;
        total_cnt++; if (flit_out_wr !== 1'b0) $display("FAIL rst_flit_wr: got %b want 0", flit_out_wr); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (credit_out !== 1'b0 || rx_ovf !== 1'b0 || tx_err !== 1'b0) $display("FAIL rst_flags: got %b%b%b want 000", credit_out, rx_ovf, tx_err); else pass_cnt++;
        reset = 1'b0;
        step();
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL post_rst_req_ready: got %b want 1", tx_req_ready); else pass_cnt++;
        total_cnt++; if (rx_src !== 2'd0 || tx_data_ready !== 1'b0) $display("FAIL post_rst_state: got src=%0d dready=%b want 0 0", rx_src, tx_data_ready); else pass_cnt++;
    endtask

    task automatic test_basic_packet();
        credit_in = 1'b1;
        tx_req_valid = 1'b1; tx_dst = 2'd3; tx_len = 5'd2;
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL basic_req_ready: got %b want 1", tx_req_ready); else pass_cnt++;
        step();
        tx_req_valid = 1'b0;
        total_cnt++; if (flit_out_wr !== 1'b0 || tx_req_ready !== 1'b0) $display("FAIL basic_head_state: got wr=%b rdy=%b want 0 0", flit_out_wr, tx_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (flit_out_wr !== 1'b1 || flit_out !== 32'h8000_0027) $display("FAIL basic_header: got wr=%b %h want 1 80000027", flit_out_wr, flit_out); else pass_cnt++;
        total_cnt++; if (tx_data_ready !== 1'b1) $display("FAIL basic_data_ready: got %b want 1", tx_data_ready); else pass_cnt++;
        tx_data_valid = 1'b1; tx_data = 30'hA;
        step();
        total_cnt++; if (flit_out_wr !== 1'b1 || flit_out !== 32'h0000_000A) $display("FAIL basic_body0: got wr=%b %h want 1 0000000a", flit_out_wr, flit_out); else pass_cnt++;
        tx_data = 30'hB;
        step();
        tx_data_valid = 1'b0; credit_in = 1'b0;
        total_cnt++; if (flit_out_wr !== 1'b1 || flit_out !== 32'h4000_000B) $display("FAIL basic_body1_tail: got wr=%b %h want 1 4000000b", flit_out_wr, flit_out); else pass_cnt++;
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL basic_req_ready_return: got %b want 1", tx_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (flit_out_wr !== 1'b0) $display("FAIL basic_idle_wr: got %b want 0", flit_out_wr); else pass_cnt++;
    endtask

    task automatic test_credit_stall();
        int n;
        logic [31:0] last;
        n = 0; last = '0;
        tx_req_valid = 1'b1; tx_dst = 2'd3; tx_len = 5'd7;
        step();
        tx_req_valid = 1'b0; tx_data_valid = 1'b1; tx_data = 30'h155;
        for (int i = 0; i < 8; i++) begin
            step();
            if (flit_out_wr === 1'b1) begin n++; last = flit_out; end
        end
        total_cnt++; if (n !== 4) $display("FAIL stall_flit_count: got %0d want 4", n); else pass_cnt++;
        total_cnt++; if (last !== 32'h0000_0155) $display("FAIL stall_last_flit: got %h want 00000155", last); else pass_cnt++;
        total_cnt++; if (tx_data_ready !== 1'b0 || flit_out_wr !== 1'b0) $display("FAIL stall_blocked: got rdy=%b wr=%b want 0 0", tx_data_ready, flit_out_wr); else pass_cnt++;
        for (int p = 0; p < 3; p++) begin
            credit_in = 1'b1;
            step();
            credit_in = 1'b0;
            n = 0;
            for (int j = 0; j < 3; j++) begin
                step();
                if (flit_out_wr === 1'b1) n++;
            end
            total_cnt++; if (n !== 1) $display("FAIL stall_credit_release%0d: got %0d flits want 1", p, n); else pass_cnt++;
        end
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        step();
        tx_data_valid = 1'b0;
        total_cnt++; if (flit_out_wr !== 1'b1 || flit_out !== 32'h4000_0155) $display("FAIL stall_tail: got wr=%b %h want 1 40000155", flit_out_wr, flit_out); else pass_cnt++;
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL stall_req_ready_return: got %b want 1", tx_req_ready); else pass_cnt++;
        credit_in = 1'b1;
        repeat (4) step();
        credit_in = 1'b0;
    endtask

    task automatic test_error();
        src_id = 2'd2;
        tx_req_valid = 1'b1; tx_dst = 2'd2; tx_len = 5'd1;
        step();
        tx_req_valid = 1'b0;
        total_cnt++; if (tx_err !== 1'b1 || flit_out_wr !== 1'b0) $display("FAIL err_self_dst: got err=%b wr=%b want 1 0", tx_err, flit_out_wr); else pass_cnt++;
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL err_stays_idle: got %b want 1", tx_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (tx_err !== 1'b0 || flit_out_wr !== 1'b0) $display("FAIL err_pulse_end: got err=%b wr=%b want 0 0", tx_err, flit_out_wr); else pass_cnt++;
        tx_req_valid = 1'b1; tx_dst = 2'd0; tx_len = 5'd17;
        step();
        tx_req_valid = 1'b0;
        total_cnt++; if (tx_err !== 1'b1) $display("FAIL err_len17: got %b want 1", tx_err); else pass_cnt++;
        step();
        total_cnt++; if (tx_err !== 1'b0 || flit_out_wr !== 1'b0 || tx_req_ready !== 1'b1) $display("FAIL err_len17_after: got err=%b wr=%b rdy=%b want 0 0 1", tx_err, flit_out_wr, tx_req_ready); else pass_cnt++;
        src_id = 2'd1;
    endtask

    task automatic test_zero_len();
        tx_req_valid = 1'b1; tx_dst = 2'd2; tx_len = 5'd0;
        step();
        tx_req_valid = 1'b0;
        step();
        total_cnt++; if (flit_out_wr !== 1'b1 || flit_out !== 32'hC000_0006) $display("FAIL zero_len_flit: got wr=%b %h want 1 c0000006", flit_out_wr, flit_out); else pass_cnt++;
        total_cnt++; if (tx_req_ready !== 1'b1) $display("FAIL zero_len_idle: got %b want 1", tx_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (flit_out_wr !== 1'b0) $display("FAIL zero_len_single: got %b want 0", flit_out_wr); else pass_cnt++;
    endtask

    task automatic test_rx();
        rx_ready = 1'b1;
        flit_in = 32'h8000_000D; flit_in_wr = 1'b1;
        step();
        flit_in = 32'h0000_0011;
        total_cnt++; if (rx_valid !== 1'b1 || rx_head !== 1'b1 || rx_tail !== 1'b0 || rx_data !== 30'h0D) $display("FAIL rx_hdr: got v=%b h=%b t=%b %h want 1 1 0 0000000d", rx_valid, rx_head, rx_tail, rx_data); else pass_cnt++;
        total_cnt++; if (rx_src !== 2'd3 || credit_out !== 1'b0) $display("FAIL rx_hdr_src: got src=%0d crd=%b want 3 0", rx_src, credit_out); else pass_cnt++;
        step();
        flit_in = 32'h4000_0022;
        total_cnt++; if (rx_valid !== 1'b1 || rx_head !== 1'b0 || rx_data !== 30'h11) $display("FAIL rx_body0: got v=%b h=%b %h want 1 0 00000011", rx_valid, rx_head, rx_data); else pass_cnt++;
        total_cnt++; if (rx_src !== 2'd3 || credit_out !== 1'b1) $display("FAIL rx_body0_src_crd: got src=%0d crd=%b want 3 1", rx_src, credit_out); else pass_cnt++;
        step();
        flit_in_wr = 1'b0;
        total_cnt++; if (rx_data !== 30'h22 || rx_tail !== 1'b1) $display("FAIL rx_body1: got %h t=%b want 00000022 1", rx_data, rx_tail); else pass_cnt++;
        total_cnt++; if (rx_src !== 2'd3 || credit_out !== 1'b1) $display("FAIL rx_body1_src_crd: got src=%0d crd=%b want 3 1", rx_src, credit_out); else pass_cnt++;
        step();
        total_cnt++; if (rx_valid !== 1'b0 || credit_out !== 1'b1) $display("FAIL rx_third_credit: got v=%b crd=%b want 0 1", rx_valid, credit_out); else pass_cnt++;
        step();
        total_cnt++; if (credit_out !== 1'b0) $display("FAIL rx_credit_end: got %b want 0", credit_out); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic crd_seen;
        crd_seen = 1'b0;
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flit_in = 32'h101 + i; flit_in_wr = 1'b1;
            step();
            crd_seen = crd_seen | credit_out;
        end
        flit_in_wr = 1'b0;
        total_cnt++; if (rx_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", rx_ovf); else pass_cnt++;
        total_cnt++; if (crd_seen !== 1'b0) $display("FAIL ovf_no_credit: got %b want 0", crd_seen); else pass_cnt++;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (rx_valid !== 1'b1 || rx_data !== 30'(32'h101 + i)) $display("FAIL ovf_entry%0d: got v=%b %h want 1 %h", i, rx_valid, rx_data, 30'(32'h101 + i)); else pass_cnt++;
            step();
        end
        rx_ready = 1'b0;
        total_cnt++; if (rx_valid !== 1'b0 || rx_ovf !== 1'b1) $display("FAIL ovf_drained_sticky: got v=%b ovf=%b want 0 1", rx_valid, rx_ovf); else pass_cnt++;
        flit_in = 32'h0000_0777; flit_in_wr = 1'b1;
        step();
        flit_in_wr = 1'b0;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovf_refill: got %b want 1", rx_valid); else pass_cnt++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        total_cnt++; if (rx_valid !== 1'b0 || rx_ovf !== 1'b0) $display("FAIL ovf_reset_clear: got v=%b ovf=%b want 0 0", rx_valid, rx_ovf); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; src_id = 2'd1;
        tx_req_valid = 1'b0; tx_dst = '0; tx_len = '0;
        tx_data_valid = 1'b0; tx_data = '0; credit_in = 1'b0;
        flit_in = '0; flit_in_wr = 1'b0; rx_ready = 1'b0;
        test_reset();
        test_basic_packet();
        test_credit_stall();
        test_error();
        test_zero_len();
        test_rx();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
